// File: rtl/ysyx_23060201_ifu_if.sv
// Bundle of the IFU handshake channels: memory request/response,
// instruction handoff to decode/execute, and next-PC return.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on a rising clock edge where both valid and ready are 1. Once
// valid is raised, the producer holds it and its payload steady until
// that edge. npc_valid has no ready; it is consumed only while the IFU
// is waiting for it.
interface ysyx_23060201_ifu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        npc_valid;
  logic [31:0] dnpc;

  // IFU side
  modport master (
    output mem_req_valid, mem_req_addr, mem_resp_ready,
    output inst_valid, inst, pc, inst_fault,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  inst_ready, npc_valid, dnpc
  );

  // Memory and decode/execute side
  modport slave (
    input  mem_req_valid, mem_req_addr, mem_resp_ready,
    input  inst_valid, inst, pc, inst_fault,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output inst_ready, npc_valid, dnpc
  );
endinterface

// File: rtl/ysyx_23060201_ifu.sv
// Multi-cycle instruction fetch unit: one outstanding fetch, hands the
// word to decode/execute, then waits for the next PC before fetching again.
module ysyx_23060201_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060201_ifu_if.master         bus,
  output logic [31:0]                 retire_cnt,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [31:0] cnt_q;
  logic        npc_misaligned;

  assign npc_misaligned = (bus.dnpc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; each state only reacts to its own handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (bus.mem_req_ready)  state_nxt = S_WAIT;
      S_WAIT: if (bus.mem_resp_valid) state_nxt = S_HOLD;
      S_HOLD: if (bus.inst_ready)     state_nxt = S_EXEC;
      S_EXEC: if (bus.npc_valid)      state_nxt = npc_misaligned ? S_HOLD : S_REQ;
      default:                        state_nxt = S_REQ;
    endcase
  end

  // Datapath: capture the fetched word, update PC and retire count
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
      cnt_q   <= 32'h0000_0000;
    end else begin
      if (state == S_WAIT && bus.mem_resp_valid) begin
        // A faulted fetch never exposes whatever data came back
        inst_q  <= bus.mem_resp_err ? 32'h0000_0000 : bus.mem_resp_data;
        fault_q <= bus.mem_resp_err;
      end
      if (state == S_EXEC && bus.npc_valid) begin
        pc_q  <= bus.dnpc;
        cnt_q <= cnt_q + 32'd1;
        // Misaligned target: skip memory, present a faulted slot directly
        if (npc_misaligned) begin
          inst_q  <= 32'h0000_0000;
          fault_q <= 1'b1;
        end
      end
    end
  end

  // Moore outputs decoded from the registered state
  assign bus.mem_req_valid  = (state == S_REQ);
  assign bus.mem_req_addr   = pc_q;
  assign bus.mem_resp_ready = (state == S_WAIT);
  assign bus.inst_valid     = (state == S_HOLD);
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.inst_fault     = fault_q;
  assign retire_cnt         = cnt_q;
  assign dbg_state          = state;

endmodule
